// File: rtl/router_pkt_src.sv
// router_pkt_src: buffered packet source for the 1x3 router input port.
// Loads a full payload, then bursts header, payload and parity under busy.
module router_pkt_src #(
  parameter int MAX_LEN = 63
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic       bad_parity,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       len_err
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      addr_q, addr_d;
  logic [5:0]      len_q, len_d;
  logic            inv_q, inv_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [AW-1:0]   rcnt_q, rcnt_d;
  logic [7:0]      acc_q, acc_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            tx_active_q, tx_active_d;
  logic            done_q, done_d;
  logic            len_err_q, len_err_d;

  logic [7:0]      mem_q [MAX_LEN];
  logic            wr_en;
  logic [AW-1:0]   last_idx;
  logic [7:0]      acc_nxt;

  assign pl_ready  = (state_q == S_LOAD);
  assign wr_en     = pl_ready && pl_valid;
  assign last_idx  = AW'(len_q - 6'd1);
  assign acc_nxt   = acc_q ^ data_out_q;

  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign tx_active = tx_active_q;
  assign done      = done_q;
  assign len_err   = len_err_q;

  // Payload buffer write; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wcnt_q] <= pl_data;
  end

  // Next-state and registered-output decode; busy freezes all TX state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    inv_d       = inv_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    acc_d       = acc_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    len_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (payload_len == 6'd0) begin
            len_err_d = 1'b1;
          end else begin
            addr_d  = dest_addr;
            len_d   = payload_len;
            inv_d   = bad_parity;
            wcnt_d  = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (pl_valid) begin
          wcnt_d = wcnt_q + AW'(1);
          if (wcnt_q == last_idx) begin
            state_d     = S_HEADER;
            pkt_valid_d = 1'b1;
            data_out_d  = {len_q, addr_q};
            acc_d       = {len_q, addr_q};
          end
        end
      end
      S_HEADER: begin
        if (!busy) begin
          state_d    = S_PAYLOAD;
          rcnt_d     = '0;
          data_out_d = mem_q[0];
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          acc_d  = acc_nxt;
          rcnt_d = rcnt_q + AW'(1);
          if (rcnt_q == last_idx) begin
            state_d     = S_PARITY;
            pkt_valid_d = 1'b0;
            data_out_d  = inv_q ? ~acc_nxt : acc_nxt;
          end else begin
            data_out_d = mem_q[rcnt_q + AW'(1)];
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          state_d    = S_GAP;
          data_out_d = 8'h00;
          done_d     = 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        pkt_valid_d = 1'b0;
        data_out_d  = 8'h00;
      end
    endcase
    tx_active_d = (state_d != S_IDLE);
  end

  // State, latched descriptor, counters and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      inv_q       <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      acc_q       <= '0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= '0;
      tx_active_q <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      inv_q       <= inv_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      acc_q       <= acc_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      tx_active_q <= tx_active_d;
      done_q      <= done_d;
      len_err_q   <= len_err_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: directed bench for router_pkt_src.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_router_pkt_src;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       bad_parity;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       len_err;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_cnt;
  logic [7:0] pay [64];
  logic [7:0] par_model;

  always #5 clk = ~clk;

  router_pkt_src #(.MAX_LEN(63)) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .dest_addr(dest_addr),
    .payload_len(payload_len),
    .bad_parity(bad_parity),
    .pl_data(pl_data),
    .pl_valid(pl_valid),
    .pl_ready(pl_ready),
    .busy(busy),
    .pkt_valid(pkt_valid),
    .data_out(data_out),
    .tx_active(tx_active),
    .done(done),
    .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] a, input logic [5:0] l,
                          input logic bp);
    start       = 1'b1;
    dest_addr   = a;
    payload_len = l;
    bad_parity  = bp;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_payload(input int n, input bit toggle);
    int i = 0;
    int g = 0;
    rdy_cnt = 0;
    while (i < n && g < 1000) begin
      if (toggle && g[0]) begin
        pl_valid = 1'b0;
      end else begin
        pl_valid = 1'b1;
        pl_data  = pay[i];
        i++;
      end
      g++;
      @(negedge clk);
      if (pl_ready) rdy_cnt++;
    end
    pl_valid = 1'b0;
    chk("load_bound", (i == n) ? 8'd1 : 8'd0, 8'd1);
  endtask

  task automatic check_tx(input int n, input logic [7:0] hdr,
                          input logic [7:0] par, input int busy_at,
                          input int busy_n);
    logic [7:0] e;
    logic       ev;
    for (int k = 0; k < n + 2; k++) begin
      if (k == 0) e = hdr;
      else if (k <= n) e = pay[k-1];
      else e = par;
      ev = (k <= n);
      chk("tx_data", data_out, e);
      chk("tx_pvld", {7'd0, pkt_valid}, {7'd0, ev});
      if (k == busy_at) begin
        busy = 1'b1;
        for (int j = 0; j < busy_n; j++) begin
          @(negedge clk);
          chk("hold_data", data_out, e);
          chk("hold_pvld", {7'd0, pkt_valid}, {7'd0, ev});
        end
        busy = 1'b0;
      end
      @(negedge clk);
    end
    chk("gap_done", {7'd0, done}, 8'd1);
    chk("gap_pvld", {7'd0, pkt_valid}, 8'd0);
    chk("gap_data", data_out, 8'h00);
    chk("gap_txact", {7'd0, tx_active}, 8'd1);
    @(negedge clk);
    chk("idle_done", {7'd0, done}, 8'd0);
    chk("idle_txact", {7'd0, tx_active}, 8'd0);
  endtask

  task automatic pkt_a(input logic bp, input logic [7:0] par,
                       input int busy_at, input int busy_n);
    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    do_start(2'd2, 6'd8, bp);
    chk("load_ready", {7'd0, pl_ready}, 8'd1);
    chk("load_txact", {7'd0, tx_active}, 8'd1);
    send_payload(8, 1'b0);
    chk("rdy_cnt8", 8'(rdy_cnt), 8'd7);
    check_tx(8, 8'h22, par, busy_at, busy_n);
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    dest_addr = 2'd0;
    payload_len = 6'd0;
    bad_parity = 1'b0;
    pl_data = 8'h00;
    pl_valid = 1'b0;
    busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pvld", {7'd0, pkt_valid}, 8'd0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_ready", {7'd0, pl_ready}, 8'd0);
    chk("rst_txact", {7'd0, tx_active}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_lenerr", {7'd0, len_err}, 8'd0);
    rstn = 1'b1;
    @(negedge clk);

    pkt_a(1'b0, 8'h2A, -1, 0);
    pkt_a(1'b1, 8'hD5, -1, 0);
    pkt_a(1'b0, 8'h2A, 4, 3);
    pkt_a(1'b0, 8'h2A, 9, 3);

    do_start(2'd1, 6'd0, 1'b0);
    chk("lenerr_hi", {7'd0, len_err}, 8'd1);
    chk("lenerr_ready", {7'd0, pl_ready}, 8'd0);
    chk("lenerr_txact", {7'd0, tx_active}, 8'd0);
    chk("lenerr_pvld", {7'd0, pkt_valid}, 8'd0);
    @(negedge clk);
    chk("lenerr_lo", {7'd0, len_err}, 8'd0);
    chk("lenerr_ready2", {7'd0, pl_ready}, 8'd0);

    par_model = 8'hFC;
    for (int i = 0; i < 63; i++) begin
      pay[i] = 8'(i * 37 + 11);
      par_model = par_model ^ pay[i];
    end
    do_start(2'd0, 6'd63, 1'b0);
    chk("l63_ready", {7'd0, pl_ready}, 8'd1);
    send_payload(63, 1'b1);
    chk("rdy_cnt63", 8'(rdy_cnt), 8'd124);
    check_tx(63, 8'hFC, par_model, -1, 0);

    for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
    do_start(2'd2, 6'd8, 1'b0);
    send_payload(8, 1'b0);
    chk("abort_hdr", data_out, 8'h22);
    repeat (5) @(negedge clk);
    chk("abort_b5", data_out, 8'h05);
    chk("abort_pv", {7'd0, pkt_valid}, 8'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_pvld", {7'd0, pkt_valid}, 8'd0);
    chk("async_data", data_out, 8'h00);
    chk("async_txact", {7'd0, tx_active}, 8'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    pay[0] = 8'hAA;
    do_start(2'd1, 6'd1, 1'b0);
    send_payload(1, 1'b0);
    check_tx(1, 8'h05, 8'hAF, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Packet transmitter for the 1x3 router's input port. It drives the same pkt_valid/data byte stream that the router's register stage consumes.
- Accepts a packet descriptor (destination, payload length) plus a payload byte stream, and buffers the full payload internally.
- Then emits header, payload and parity as a gap-free burst, honouring router busy back-pressure.
- Used as the synthesizable traffic source in router system benches and FPGA loopback.

Parameters:
- MAX_LEN, 63: maximum payload bytes; sets buffer depth. The header length field is fixed at 6 bits.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to send a packet; sampled only in IDLE
- dest_addr  input  2  destination port 0..2; value 3 is passed through unchecked
- payload_len  input  6  payload byte count, 1..63
- bad_parity  input  1  when set at start, the transmitted parity byte is bitwise-inverted
- pl_data  input  8  payload byte
- pl_valid  input  1  pl_data valid
- pl_ready  output  1  block accepts a payload byte this cycle
- busy  input  1  router busy; when high, the current output byte is held
- pkt_valid  output  1  high during header and payload bytes
- data_out  output  8  byte to the router data_in
- tx_active  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse after the parity byte is accepted
- len_err  output  1  one-cycle pulse when start arrives with payload_len==0

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; pkt_valid=0, data_out=0x00, pl_ready=0, tx_active=0, done=0, len_err=0; counters and parity accumulator cleared. Buffer contents are not reset.
- All outputs except pl_ready are registered. pl_ready = (state==LOAD), decoded from registered state.
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE:
  - start with payload_len!=0: latch dest_addr, payload_len, bad_parity; go to LOAD.
  - start with payload_len==0: len_err=1 for the next cycle; stay in IDLE.
  - start in any other state is ignored.
- LOAD:
  - Each edge with pl_valid&pl_ready writes buffer[wcnt] and increments wcnt.
  - The write of byte number len-1 moves to HEADER.
  - pl_valid gaps simply stall; no timeout.
- Byte transfer rule, all TX states: a byte is accepted on a rising edge where busy==0. While busy==1, data_out and pkt_valid hold and the parity accumulator does not update.
- HEADER:
  - pkt_valid=1, data_out={len,addr}; the accumulator is seeded with the header value.
  - On accept, go to PAYLOAD with rcnt=0.
- PAYLOAD:
  - pkt_valid=1, data_out=buffer[rcnt].
  - On accept, XOR the byte into the accumulator and increment rcnt.
  - Acceptance of the last byte (rcnt==len-1) moves to PARITY.
- PARITY:
  - pkt_valid=0, data_out=acc, or ~acc if bad_parity latched.
  - On accept, go to GAP.
- GAP:
  - pkt_valid=0, data_out=0x00, done=1 for this single cycle.
  - Next edge goes to IDLE.
  - The minimum one-cycle gap guarantees a pkt_valid low between back-to-back packets.
- Latency with busy=0: header appears in the cycle after the edge that wrote the final payload byte. Header to IDLE takes exactly len+3 cycles.
- Parity is the XOR over header plus all payload bytes, 8-bit. Inversion is bitwise, not logical.
- Reset mid-operation aborts the packet: outputs go to zero immediately and the partial packet is dropped. The next start behaves normally.
- busy asserted in HEADER or PARITY holds those bytes identically to PAYLOAD.

Test Plan:
- len=8, addr=2, payload 0x01..0x08, busy=0 -> data_out 0x22, 0x01..0x08 with pkt_valid=1 for 9 cycles; then 0x2A with pkt_valid=0; done pulses in the following cycle; tx_active low after 11 cycles from header.
- Same packet with bad_parity=1 -> parity byte 0xD5; all other bytes identical.
- Same packet with busy high for 3 cycles while byte 0x04 is on data_out -> 0x04 and pkt_valid=1 held 4 cycles total; final parity still 0x2A. Repeat with busy during PARITY -> 0x2A held.
- start with payload_len=0 -> len_err high exactly one cycle; state stays IDLE; pl_ready stays 0; no pkt_valid.
- len=63, addr=0, pl_valid toggling every other cycle -> pl_ready high for about 126 cycles; header 0xFC; 63 payload bytes with no pkt_valid gaps; parity matches the XOR model.
- rstn pulsed low while in PAYLOAD byte 5 -> pkt_valid and data_out go to 0 without waiting for clk. A new start with len=1, addr=1, byte 0xAA then yields 0x05, 0xAA, parity 0xAF.
